// File: rtl/mips_mem_pkg.sv
// Shared encodings and constants for the MIPS multicycle memory port.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mem_state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 15;

  // Clears the byte-offset bits of a word address.
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr & ~WORD_ALIGN_MASK) == 32'h0;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles spent waiting for memory; expired flags the cycle whose
// increment would bring the count up to the limit.
module mem_timeout_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count;

  // NOTE: sequential state is written with <= only, so every flop in the
  // design samples its inputs from before the edge.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = enable && (({1'b0, count} + 9'd1) == {1'b0, limit});

endmodule

// File: rtl/mips_mem_port.sv
// Memory port between the MIPS multicycle control unit and an external
// handshaked memory. Optional build macro: MEM_ALIGN_CHECK_EN.
module mips_mem_port
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] ALUOut,
  input  logic [31:0] B,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IRWrite,
  output logic [31:0] Instr,
  output logic [31:0] Data,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err,
  output logic        align_err
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  mem_state_t  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        irw_q;

  logic        strobe;
  logic [31:0] req_addr;
  logic        ctr_clear;
  logic        ctr_enable;
  logic        expired;

  assign strobe     = MemRead | MemWrite;
  assign req_addr   = IorD ? ALUOut : PC;
  assign ctr_clear  = (state == ST_IDLE) && strobe;
  assign ctr_enable = (state == ST_BUSY) && !mem_ready;

  mem_timeout_ctr u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .limit   (TIMEOUT_LIMIT),
    .expired (expired)
  );

`ifdef MEM_ALIGN_CHECK_EN
  logic align_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: every register here, including Instr and Data, has a defined
      // reset value; a reset mid-transaction simply drops the transfer.
      state   <= ST_IDLE;
      Instr   <= 32'h0;
      Data    <= 32'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      irw_q   <= 1'b0;
      bus_err <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      align_q <= 1'b0;
`endif
    end else begin
      bus_err <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      align_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (strobe) begin
            addr_q  <= req_addr;
            wdata_q <= B;
            we_q    <= MemWrite;  // read+write together resolves to a write
            irw_q   <= IRWrite;
`ifdef MEM_ALIGN_CHECK_EN
            if (!is_word_aligned(req_addr)) begin
              align_q <= 1'b1;
              state   <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
`else
            state <= ST_BUSY;
`endif
          end
        end
        ST_BUSY: begin
          // Completion is checked first so a late ready still beats the abort.
          if (mem_ready) begin
            if (!we_q) begin
              Data <= mem_rdata;
              if (irw_q) begin
                Instr <= mem_rdata;
              end
            end
            state <= ST_DONE;
          end else if (expired) begin
            bus_err <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Stall     = (state == ST_BUSY) || ((state == ST_IDLE) && strobe);
  assign mem_req   = (state == ST_BUSY);
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;

`ifdef MEM_ALIGN_CHECK_EN
  assign mem_addr  = addr_q;
  assign align_err = align_q;
`else
  assign mem_addr  = addr_q & WORD_ALIGN_MASK;
  assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mem_port.sv
// Directed self-checking bench for mips_mem_port (default TIMEOUT_CYCLES=15).
module tb_mips_mem_port;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] ALUOut;
  logic [31:0] B;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic [31:0] Instr;
  logic [31:0] Data;
  logic        Stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;
  logic        align_err;

  int n_cmp = 0;
  int n_err = 0;

  mips_mem_port dut (
    .clk       (clk),
    .reset     (reset),
    .PC        (PC),
    .ALUOut    (ALUOut),
    .B         (B),
    .IorD      (IorD),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .Instr     (Instr),
    .Data      (Data),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .bus_err   (bus_err),
    .align_err (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Registers have settled 2 time units after each rising edge; inputs are
  // driven here and combinational outputs sampled one unit later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic strobes_off();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; PC = '0; ALUOut = '0; B = '0; IorD = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
    mem_rdata = '0; mem_ready = 1'b0;
    cyc(); cyc();

    // Reset state
    check("rst_instr", Instr, 32'h0);
    check("rst_data", Data, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check_bit("rst_req", mem_req, 1'b0);
    check_bit("rst_we", mem_we, 1'b0);
    check_bit("rst_stall", Stall, 1'b0);
    check_bit("rst_bus_err", bus_err, 1'b0);
    check_bit("rst_align_err", align_err, 1'b0);
    reset = 1'b1;
    cyc();

    // Fetch: ready two cycles after mem_req rises
    PC = 32'h0040_0000; IorD = 1'b0; MemRead = 1'b1; IRWrite = 1'b1;
    #1;
    check_bit("fetch_idle_stall", Stall, 1'b1);
    check_bit("fetch_idle_req", mem_req, 1'b0);
    cyc();
    check_bit("fetch_b1_req", mem_req, 1'b1);
    check("fetch_b1_addr", mem_addr, 32'h0040_0000);
    check_bit("fetch_b1_we", mem_we, 1'b0);
    check_bit("fetch_b1_stall", Stall, 1'b1);
    cyc();
    check_bit("fetch_b2_req", mem_req, 1'b1);
    check("fetch_b2_data", Data, 32'h0);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h8C82_0004;
    #1;
    check_bit("fetch_b3_stall", Stall, 1'b1);
    cyc();
    mem_ready = 1'b0;
    #1;
    check_bit("fetch_done_stall", Stall, 1'b0);
    check_bit("fetch_done_req", mem_req, 1'b0);
    check("fetch_instr", Instr, 32'h8C82_0004);
    check("fetch_data", Data, 32'h8C82_0004);
    cyc();
    // Back in IDLE with the strobe still held: Stall is high again
    #1;
    check_bit("fetch_idle_again_stall", Stall, 1'b1);
    strobes_off();
    #1;
    check_bit("idle_no_strobe_stall", Stall, 1'b0);
    cyc();

    // Store with ready already high (ignored in IDLE, completes first BUSY cycle)
    ALUOut = 32'h1001_0008; B = 32'hDEAD_BEEF; IorD = 1'b1; MemWrite = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    check_bit("store_idle_stall", Stall, 1'b1);
    cyc();
    check_bit("store_busy_req", mem_req, 1'b1);
    check_bit("store_busy_we", mem_we, 1'b1);
    check("store_busy_addr", mem_addr, 32'h1001_0008);
    check("store_busy_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    strobes_off();
    #1;
    check_bit("store_done_stall", Stall, 1'b0);
    check("store_data_kept", Data, 32'h8C82_0004);
    check("store_instr_kept", Instr, 32'h8C82_0004);
    cyc();

    // MemRead and MemWrite together act as a write
    ALUOut = 32'h1001_0010; B = 32'h0BAD_F00D; IorD = 1'b1;
    MemRead = 1'b1; MemWrite = 1'b1; IRWrite = 1'b1;
    cyc();
    check_bit("rw_busy_we", mem_we, 1'b1);
    check("rw_busy_wdata", mem_wdata, 32'h0BAD_F00D);
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    cyc();
    strobes_off();
    check("rw_data_kept", Data, 32'h8C82_0004);
    check("rw_instr_kept", Instr, 32'h8C82_0004);
    cyc();

    // Load that never completes: 15 BUSY cycles then bus_err in DONE
    ALUOut = 32'h1001_0000; IorD = 1'b1; MemRead = 1'b1; IRWrite = 1'b1;
    mem_rdata = 32'hAAAA_AAAA;
    cyc();
    for (int i = 0; i < 15; i++) begin
      check_bit("to_busy_req", mem_req, 1'b1);
      check_bit("to_busy_bus_err", bus_err, 1'b0);
      cyc();
    end
    strobes_off();
    #1;
    check_bit("to_done_bus_err", bus_err, 1'b1);
    check_bit("to_done_req", mem_req, 1'b0);
    check_bit("to_done_stall", Stall, 1'b0);
    check("to_instr_kept", Instr, 32'h8C82_0004);
    check("to_data_kept", Data, 32'h8C82_0004);
    cyc();
    check_bit("to_idle_bus_err", bus_err, 1'b0);
    check_bit("to_idle_req", mem_req, 1'b0);

    // Ready arrives on the expiry cycle: completion wins
    ALUOut = 32'h1001_0020; MemRead = 1'b1; IRWrite = 1'b0;
    cyc();
    for (int i = 0; i < 14; i++) cyc();
    check_bit("race_b15_req", mem_req, 1'b1);
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    cyc();
    strobes_off();
    check_bit("race_bus_err", bus_err, 1'b0);
    check("race_data", Data, 32'h1111_2222);
    check("race_instr_kept", Instr, 32'h8C82_0004);
    cyc();

    // Reset during BUSY abandons the load; late ready is ignored
    ALUOut = 32'h1001_0030; MemRead = 1'b1; IRWrite = 1'b1;
    cyc();
    check_bit("rb_busy_req", mem_req, 1'b1);
    reset = 1'b0;
    cyc();
    check_bit("rb_req", mem_req, 1'b0);
    check("rb_instr", Instr, 32'h0);
    check("rb_data", Data, 32'h0);
    check("rb_addr", mem_addr, 32'h0);
    reset = 1'b1;
    strobes_off();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_BABE;
    cyc();
    mem_ready = 1'b0;
    check("rb_late_data", Data, 32'h0);
    check("rb_late_instr", Instr, 32'h0);
    check_bit("rb_late_req", mem_req, 1'b0);
    cyc();

    // Misaligned load
    ALUOut = 32'h1001_0006; IorD = 1'b1; MemRead = 1'b1; IRWrite = 1'b0;
    cyc();
`ifdef MEM_ALIGN_CHECK_EN
    strobes_off();
    #1;
    check_bit("mis_align_err", align_err, 1'b1);
    check_bit("mis_req", mem_req, 1'b0);
    check_bit("mis_stall", Stall, 1'b0);
    cyc();
    check_bit("mis_align_err_clear", align_err, 1'b0);
`else
    check("mis_addr_forced", mem_addr, 32'h1001_0004);
    check_bit("mis_req", mem_req, 1'b1);
    check_bit("mis_align_err", align_err, 1'b0);
    mem_ready = 1'b1; mem_rdata = 32'h55AA_55AA;
    cyc();
    strobes_off();
    check("mis_data", Data, 32'h55AA_55AA);
    check("mis_instr_kept", Instr, 32'h0);
    check_bit("mis_align_err_done", align_err, 1'b0);
    cyc();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_mem_port.md
MIPS_MEM_PORT -- requirements
Module: mips_mem_port

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, max BUSY cycles waiting for mem_ready before abort (range 1..255).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- PC  in  32  fetch address.
- ALUOut  in  32  data address.
- B  in  32  store data.
- IorD  in  1  0 selects PC, 1 selects ALUOut.
- MemRead  in  1  read strobe, held by control unit.
- MemWrite  in  1  write strobe, held by control unit.
- IRWrite  in  1  read result goes to IR.
- Instr  out  32  instruction register.
- Data  out  32  memory data register (MDR).
- Stall  out  1  holds the control unit in its current state.
- mem_req  out  1  external request.
- mem_we  out  1  external write enable.
- mem_addr  out  32  external address.
- mem_wdata  out  32  external write data.
- mem_rdata  in  32  external read data.
- mem_ready  in  1  external completion, valid only while mem_req=1.
- bus_err  out  1  one-cycle timeout pulse.
- align_err  out  1  one-cycle misalignment pulse (macro builds only).

Function
REQ-003 SHALL implement FSM IDLE, BUSY, DONE.
REQ-004 IDLE: on MemRead|MemWrite, SHALL latch addr=(IorD?ALUOut:PC), wdata=B, we=MemWrite, irw=IRWrite, go BUSY.
REQ-005 Stall SHALL be combinational: 1 in IDLE with a strobe, 1 in BUSY, 0 in DONE and in idle IDLE.
REQ-006 BUSY: mem_req=1; mem_addr, mem_we, mem_wdata SHALL be held stable from latches.
REQ-007 BUSY with mem_ready=1 and we=0: SHALL load Data<=mem_rdata; if irw, also load Instr<=mem_rdata; go DONE.
REQ-008 BUSY with mem_ready=1 and we=1: SHALL leave Instr and Data unchanged; go DONE.
REQ-009 mem_req SHALL drop in the cycle after mem_ready is seen.
REQ-010 DONE: SHALL last exactly one cycle with Stall=0, ignore strobes, return to IDLE.
REQ-011 Minimum latency, strobe to Stall=0: 3 cycles (IDLE, BUSY with ready, DONE).
REQ-012 Timeout counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ready.
REQ-013 On count reaching TIMEOUT_CYCLES: SHALL abort, pulse bus_err one cycle, leave registers unchanged, go DONE.
REQ-014 MemRead and MemWrite together SHALL be treated as a write.
REQ-015 mem_ready outside BUSY SHALL be ignored.
REQ-016 mem_ready on the same cycle as timeout expiry: completion SHALL win and bus_err SHALL stay 0.

Reset
REQ-017 reset=0 at a clock edge SHALL force, from the next cycle: IDLE; Instr=0; Data=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; bus_err=0; align_err=0; counter=0.
REQ-018 Reset in BUSY SHALL abandon the transaction with no register update.

Configuration
REQ-019 With MEM_ALIGN_CHECK_EN defined: a latched address with addr[1:0]!=00 SHALL skip BUSY, assert no mem_req, pulse align_err, and go DONE.
REQ-020 Without MEM_ALIGN_CHECK_EN: mem_addr[1:0] SHALL be forced to 00 and align_err SHALL be tied to 0.

Structure
REQ-021 Package mips_mem_pkg SHALL hold the FSM state encoding (2 bits), the TIMEOUT_CYCLES default, and the word-alignment mask constant.
REQ-022 The timeout counter SHALL be sub-module mem_timeout_ctr (clear, enable, limit; expired output); everything else stays in the top.

Verification
REQ-023 Fetch, PC=0x00400000, IorD=0, IRWrite=1, mem_ready 2 cycles after mem_req with rdata=0x8C820004 -> Instr=Data=0x8C820004, Stall=0 for exactly one cycle.
REQ-024 Store, ALUOut=0x10010008, B=0xDEADBEEF, IorD=1, MemWrite=1, ready immediately -> mem_we=1, mem_addr=0x10010008, mem_wdata=0xDEADBEEF, Data unchanged, 3-cycle latency.
REQ-025 Load with mem_ready never asserted, TIMEOUT_CYCLES=15 -> bus_err pulse after 15 BUSY cycles, Instr/Data unchanged, FSM passes DONE then IDLE.
REQ-026 reset=0 during BUSY of a load -> next cycle mem_req=0, Instr=0, Data=0; late mem_ready ignored.
REQ-027 Load at ALUOut=0x10010006 -> with MEM_ALIGN_CHECK_EN: align_err=1, no mem_req; without: mem_addr=0x10010004.
